tri_read_arbiter: RTL and testbench
===================================

// Module: tri_read_arbiter
// PURPOSE
//  Shares one triangle-fetch port (cached SDRAM triangle reader) among NREQ ray/intersect
//  units. Round-robin arbitration; one outstanding fetch at a time. Grants a requester,
//  drives its index to the reader, holds read until the reader's ovalid, registers the
//  block, returns it to the granted requester with a one-cycle valid pulse.
// PARAMETERS
//  NREQ     4   number of requesters (2..16)
//  NDWORDS  9   32-bit words per triangle block
//  BLOCKSZ  32*NDWORDS (localparam)  triangle block width in bits
// PORTS
//  clk          in   1             clock
//  reset        in   1             synchronous, active-high reset
//  req_read     in   NREQ          per-requester fetch request (level)
//  req_index    in   32*NREQ       per-requester tri index; slice r = [32*r +: 32]
//  req_data     out  BLOCKSZ       returned block (shared bus), valid with req_valid
//  req_valid    out  NREQ          one-hot, one-cycle pulse to the served requester
//  tr_read      out  1             read to triangle reader
//  tr_index     out  32            index to triangle reader
//  tr_iready    in   1             triangle reader can accept a new read
//  tr_ovalid    in   1             triangle reader data valid
//  tr_data      in   BLOCKSZ       triangle reader data
//  max_latency  out  16            max BUSY-state cycles seen since reset (saturating)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, grant=0, req_valid=0, req_data=0, tr_read=0,
//   tr_index=0, max_latency=0. Reset mid-fetch aborts it; no req_valid is issued.
//  Requester rule: hold req_read and req_index stable until its req_valid pulse.
//  FSM (3 states):
//   IDLE: if |req_read && tr_iready -> pick first r with req_read[r] searching
//     rr_ptr, rr_ptr+1, ... mod NREQ; latch grant=r, idx_q=req_index[r]; -> BUSY.
//     Otherwise stay. tr_read=0 in IDLE.
//   BUSY: tr_read=1, tr_index=idx_q (registered, stable for whole state);
//     lat_cnt increments each cycle (saturating at 16'hFFFF).
//     On tr_ovalid: req_data<=tr_data, req_valid[grant]<=1 (next cycle),
//     rr_ptr<=(grant+1) mod NREQ, max_latency<=max(max_latency,lat_cnt+1) -> RESP.
//   RESP: tr_read=0 (one-cycle read gap so reader sees a fresh request);
//     req_valid pulse is visible in this cycle; lat_cnt<=0; -> IDLE.
//  Latency: grant in IDLE cycle t; tr_read high from t+1; ovalid at cycle u
//   gives req_valid at u+1; earliest next grant decision at u+2.
//  req_data holds its value until the next capture (not cleared after the pulse).
//  tr_ovalid outside BUSY is ignored. req_read dropped after grant: fetch still
//   completes and pulses req_valid (requester ignores it); not re-served.
//  Simultaneous requests: only rr_ptr-ordered winner served; others wait; each
//   active requester is served within NREQ fetches (no starvation).
//  Same index from different requesters: fetched separately (reader cache hits).
//  rr_ptr width = $clog2(NREQ); wrap-around NREQ-1 -> 0 explicit (non-power-of-2 NREQ).
// TESTING
//  1. Single req: req_read[2]=1, index=7, reader ovalid 1 cycle after read ->
//     tr_index=7, req_valid=4'b0100 for exactly 1 cycle, req_data=tr_data, max_latency=1.
//  2. All 4 request at once from reset -> served order 0,1,2,3; then req 1 alone
//     re-requests after req 0 -> next served 1; rr_ptr wrap 3->0 checked.
//  3. Reader miss: ovalid 25 cycles after read -> tr_read/tr_index stable all 25 cycles,
//     exactly one req_valid, max_latency=25; later 3-cycle fetch leaves it at 25.
//  4. tr_iready=0 with req pending 10 cycles -> no grant, tr_read=0; iready=1 -> grant.
//  5. Reset asserted mid-BUSY -> next cycle tr_read=0, req_valid=0, rr_ptr=0;
//     pending requests re-arbitrated from requester 0.
//  6. Spurious tr_ovalid in IDLE/RESP -> no req_valid, req_data unchanged.

Source files
------------

// File: rtl/tri_read_arbiter.sv
// Round-robin arbiter sharing one triangle-reader fetch port among NREQ units.
// One fetch in flight at a time; the fetched block is returned on a shared bus
// with a one-cycle one-hot valid pulse to the requester that was granted.
module tri_read_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned NDWORDS = 9
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_read,
   input  logic [32*NREQ-1:0]      req_index,
   output logic [32*NDWORDS-1:0]   req_data,
   output logic [NREQ-1:0]         req_valid,
   output logic                    tr_read,
   output logic [31:0]             tr_index,
   input  logic                    tr_iready,
   input  logic                    tr_ovalid,
   input  logic [32*NDWORDS-1:0]   tr_data,
   output logic [15:0]             max_latency
);

   localparam int unsigned BLOCKSZ = 32*NDWORDS;
   localparam int unsigned PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned LW      = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [PW-1:0]       rr_ptr;
   logic [PW-1:0]       grant;
   logic [PW-1:0]       pick;
   logic [PW-1:0]       cand;
   logic                pick_valid;
   logic [LW-1:0]       lat_cnt;
   logic [LW-1:0]       lat_inc;
   logic [31:0]         idx_arr [NREQ];

   logic [PW-1:0]       rr_ptr_d;
   logic [PW-1:0]       grant_d;
   logic [31:0]         tr_index_d;
   logic                tr_read_d;
   logic [NREQ-1:0]     req_valid_d;
   logic [BLOCKSZ-1:0]  req_data_d;
   logic [LW-1:0]       lat_cnt_d;
   logic [LW-1:0]       max_latency_d;

   // Modulo-NREQ addition; explicit wrap so non-power-of-2 NREQ works.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return PW'(s);
   endfunction

   // Unpack the flat per-requester index bus.
   for (genvar g = 0; g < NREQ; g++) begin : g_idx
      assign idx_arr[g] = req_index[32*g +: 32];
   end

   // Saturating increment of the busy-cycle counter.
   assign lat_inc = (lat_cnt == '1) ? lat_cnt : lat_cnt + LW'(1);

   // Round-robin pick: first active requester starting at rr_ptr.
   always_comb begin
      pick_valid = 1'b0;
      pick       = '0;
      cand       = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = wrap_add(rr_ptr, i);
         if (!pick_valid && req_read[cand]) begin
            pick_valid = 1'b1;
            pick       = cand;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_valid && tr_iready) state_d = BUSY;
         BUSY:    if (tr_ovalid) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values; registered below.
   always_comb begin
      rr_ptr_d      = rr_ptr;
      grant_d       = grant;
      tr_index_d    = tr_index;
      tr_read_d     = 1'b0;
      req_valid_d   = '0;
      req_data_d    = req_data;
      lat_cnt_d     = lat_cnt;
      max_latency_d = max_latency;
      case (state_q)
         IDLE: begin
            if (pick_valid && tr_iready) begin
               grant_d    = pick;
               tr_index_d = idx_arr[pick];
               tr_read_d  = 1'b1;
            end
         end
         BUSY: begin
            lat_cnt_d = lat_inc;
            if (tr_ovalid) begin
               req_data_d         = tr_data;
               req_valid_d[grant] = 1'b1;
               rr_ptr_d           = wrap_add(grant, 1);
               if (lat_inc > max_latency) max_latency_d = lat_inc;
            end else begin
               tr_read_d = 1'b1;
            end
         end
         RESP: begin
            lat_cnt_d = '0;
         end
         default: begin
            lat_cnt_d = '0;
         end
      endcase
   end

   // Registered outputs and arbitration state.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr      <= '0;
         grant       <= '0;
         tr_index    <= '0;
         tr_read     <= 1'b0;
         req_valid   <= '0;
         req_data    <= '0;
         lat_cnt     <= '0;
         max_latency <= '0;
      end else begin
         rr_ptr      <= rr_ptr_d;
         grant       <= grant_d;
         tr_index    <= tr_index_d;
         tr_read     <= tr_read_d;
         req_valid   <= req_valid_d;
         req_data    <= req_data_d;
         lat_cnt     <= lat_cnt_d;
         max_latency <= max_latency_d;
      end
   end

endmodule

// File: tb/tb_tri_read_arbiter.sv
// Bench for tri_read_arbiter: cycle-rule model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_tri_read_arbiter;

   localparam int NREQ    = 4;
   localparam int NDWORDS = 9;
   localparam int BLOCKSZ = 32*NDWORDS;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_read;
   logic [32*NREQ-1:0]    req_index;
   logic [BLOCKSZ-1:0]    req_data;
   logic [NREQ-1:0]       req_valid;
   logic                  tr_read;
   logic [31:0]           tr_index;
   logic                  tr_iready;
   logic                  tr_ovalid;
   logic [BLOCKSZ-1:0]    tr_data;
   logic [15:0]           max_latency;

   tri_read_arbiter #(.NREQ(NREQ), .NDWORDS(NDWORDS)) dut (
      .clk(clk), .reset(reset),
      .req_read(req_read), .req_index(req_index),
      .req_data(req_data), .req_valid(req_valid),
      .tr_read(tr_read), .tr_index(tr_index),
      .tr_iready(tr_iready), .tr_ovalid(tr_ovalid), .tr_data(tr_data),
      .max_latency(max_latency)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [BLOCKSZ-1:0] act, input logic [BLOCKSZ-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model, checked every cycle ----------------
   logic                 p_rst = 1'b1;
   logic [NREQ-1:0]      p_rd  = '0;
   logic [32*NREQ-1:0]   p_idx = '0;
   logic                 p_rdy = 1'b0;
   logic                 p_ov  = 1'b0;
   logic [BLOCKSZ-1:0]   p_dat = '0;
   bit                   m_busy = 0;
   bit                   m_resp = 0;
   int                   m_len  = 0;
   int                   m_grant = 0;
   int                   m_rr   = 0;
   int                   m_max  = 0;
   logic [31:0]          m_idx  = '0;
   logic [BLOCKSZ-1:0]   m_data = '0;
   int                   served[$];

   always @(negedge clk) begin
      int w;
      if (p_rst) begin
         chk("rst_tr_read", BLOCKSZ'(tr_read), '0);
         chk("rst_req_valid", BLOCKSZ'(req_valid), '0);
         chk("rst_req_data", req_data, '0);
         chk("rst_tr_index", BLOCKSZ'(tr_index), '0);
         chk("rst_max_latency", BLOCKSZ'(max_latency), '0);
         m_busy = 0; m_resp = 0; m_rr = 0; m_max = 0; m_data = '0;
      end else if (m_busy && p_ov) begin
         if (m_len > m_max) m_max = (m_len > 65535) ? 65535 : m_len;
         m_data = p_dat;
         chk("resp_req_valid", BLOCKSZ'(req_valid), BLOCKSZ'(1 << m_grant));
         chk("resp_req_data", req_data, m_data);
         chk("resp_max_latency", BLOCKSZ'(max_latency), BLOCKSZ'(m_max));
         chk("resp_tr_read", BLOCKSZ'(tr_read), '0);
         served.push_back(m_grant);
         m_rr = (m_grant + 1) % NREQ;
         m_busy = 0; m_resp = 1;
      end else if (m_busy) begin
         m_len++;
         chk("busy_tr_read", BLOCKSZ'(tr_read), BLOCKSZ'(1));
         chk("busy_tr_index", BLOCKSZ'(tr_index), BLOCKSZ'(m_idx));
         chk("busy_req_valid", BLOCKSZ'(req_valid), '0);
         chk("busy_req_data", req_data, m_data);
      end else if (m_resp) begin
         m_resp = 0;
         chk("gap_tr_read", BLOCKSZ'(tr_read), '0);
         chk("gap_req_valid", BLOCKSZ'(req_valid), '0);
         chk("gap_req_data", req_data, m_data);
      end else begin
         w = -1;
         if (p_rdy) begin
            for (int k = 0; k < NREQ; k++) begin
               int c;
               c = (m_rr + k) % NREQ;
               if (w < 0 && p_rd[c]) w = c;
            end
         end
         if (w >= 0) begin
            m_grant = w;
            m_idx   = p_idx[32*w +: 32];
            m_busy  = 1;
            m_len   = 1;
            chk("grant_tr_read", BLOCKSZ'(tr_read), BLOCKSZ'(1));
            chk("grant_tr_index", BLOCKSZ'(tr_index), BLOCKSZ'(m_idx));
         end else begin
            chk("idle_tr_read", BLOCKSZ'(tr_read), '0);
         end
         chk("idle_req_valid", BLOCKSZ'(req_valid), '0);
         chk("idle_req_data", req_data, m_data);
         chk("idle_max_latency", BLOCKSZ'(max_latency), BLOCKSZ'(m_max));
      end
      p_rst = reset; p_rd = req_read; p_idx = req_index;
      p_rdy = tr_iready; p_ov = tr_ovalid; p_dat = tr_data;
   end

   // ---------------- stimulus: requesters and triangle reader ----------------
   int                 want [NREQ];
   int                 lat_cfg = 1;
   logic               spur = 1'b0;
   int                 rd_cnt = 0;
   int                 rdcyc = 0;
   int                 vcount = 0;
   logic [31:0]        last_tr_index = '0;
   logic [BLOCKSZ-1:0] last_block = '0;

   function automatic logic [BLOCKSZ-1:0] rand_block();
      logic [BLOCKSZ-1:0] b;
      for (int i = 0; i < NDWORDS; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      for (int r = 0; r < NREQ; r++) begin
         if (req_valid[r]) begin
            vcount++;
            if (want[r] > 0) want[r]--;
         end
         req_read[r] = (want[r] > 0);
      end
      if (tr_read) begin
         rdcyc++;
         last_tr_index = tr_index;
         rd_cnt++;
         tr_data = rand_block();
         if (rd_cnt == lat_cfg) begin
            tr_ovalid  = 1'b1;
            last_block = tr_data;
         end else begin
            tr_ovalid = 1'b0;
         end
      end else begin
         rd_cnt    = 0;
         tr_ovalid = spur;
         tr_data   = rand_block();
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_served(input int n);
      int b;
      b = 0;
      while (served.size() < n && b < 400) begin
         step();
         b++;
      end
      chk("wait_served", BLOCKSZ'(served.size()), BLOCKSZ'(n));
   endtask

   task automatic set_index(input int r, input logic [31:0] v);
      req_index[32*r +: 32] = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int v0;
      int r0;
      logic [BLOCKSZ-1:0] saved;
      reset = 1'b1; req_read = '0; req_index = '0; tr_iready = 1'b1;
      tr_ovalid = 1'b0; tr_data = '0;
      for (int r = 0; r < NREQ; r++) want[r] = 0;
      steps(3);
      reset = 1'b0;
      steps(2);
      chk("init_max_latency", BLOCKSZ'(max_latency), '0);
      chk("init_tr_read", BLOCKSZ'(tr_read), '0);

      // 1: single request from requester 2, one-cycle reader
      s0 = served.size(); v0 = vcount;
      set_index(2, 32'd7); want[2] = 1; lat_cfg = 1;
      wait_served(s0 + 1);
      steps(3);
      chk("t1_served", BLOCKSZ'(served[s0]), BLOCKSZ'(2));
      chk("t1_tr_index", BLOCKSZ'(last_tr_index), BLOCKSZ'(7));
      chk("t1_max_latency", BLOCKSZ'(max_latency), BLOCKSZ'(1));
      chk("t1_req_data", req_data, last_block);
      chk("t1_pulses", BLOCKSZ'(vcount - v0), BLOCKSZ'(1));

      // 2: all four from reset, then re-requests exercising wrap
      reset = 1'b1; step(); reset = 1'b0;
      s0 = served.size(); lat_cfg = 2;
      for (int r = 0; r < NREQ; r++) begin
         set_index(r, 32'(10 + r));
         want[r] = 1;
      end
      wait_served(s0 + 4);
      for (int k = 0; k < 4; k++) chk("t2_order", BLOCKSZ'(served[s0+k]), BLOCKSZ'(k));
      steps(2);
      want[1] = 1;
      wait_served(s0 + 5);
      chk("t2_after0", BLOCKSZ'(served[s0+4]), BLOCKSZ'(1));
      steps(2);
      want[0] = 1; want[3] = 1;
      wait_served(s0 + 7);
      chk("t2_wrap_a", BLOCKSZ'(served[s0+5]), BLOCKSZ'(3));
      chk("t2_wrap_b", BLOCKSZ'(served[s0+6]), BLOCKSZ'(0));
      chk("t2_max_latency", BLOCKSZ'(max_latency), BLOCKSZ'(2));
      steps(2);

      // 3: long miss then a short fetch
      s0 = served.size(); v0 = vcount; r0 = rdcyc;
      set_index(1, 32'h55); want[1] = 1; lat_cfg = 25;
      wait_served(s0 + 1);
      steps(2);
      chk("t3_max_latency", BLOCKSZ'(max_latency), BLOCKSZ'(25));
      chk("t3_read_cycles", BLOCKSZ'(rdcyc - r0), BLOCKSZ'(25));
      chk("t3_pulses", BLOCKSZ'(vcount - v0), BLOCKSZ'(1));
      lat_cfg = 3; want[2] = 1;
      wait_served(s0 + 2);
      steps(2);
      chk("t3_max_hold", BLOCKSZ'(max_latency), BLOCKSZ'(25));

      // 4: reader not ready holds off the grant
      s0 = served.size(); r0 = rdcyc;
      tr_iready = 1'b0; set_index(0, 32'd99); want[0] = 1;
      steps(10);
      chk("t4_no_read", BLOCKSZ'(rdcyc - r0), '0);
      chk("t4_no_serve", BLOCKSZ'(served.size()), BLOCKSZ'(s0));
      tr_iready = 1'b1;
      wait_served(s0 + 1);
      chk("t4_served", BLOCKSZ'(served[s0]), BLOCKSZ'(0));
      steps(2);

      // 5: reset mid-fetch; pending requests restart from requester 0
      lat_cfg = 2; want[1] = 1;
      wait_served(s0 + 2);
      steps(2);
      s0 = served.size(); v0 = vcount;
      lat_cfg = 20; want[1] = 1; want[3] = 1;
      for (int i = 0; i < 20 && !tr_read; i++) step();
      chk("t5_first_grant_idx", BLOCKSZ'(tr_index), BLOCKSZ'(13));
      steps(3);
      reset = 1'b1; step(); reset = 1'b0;
      chk("t5_tr_read", BLOCKSZ'(tr_read), '0);
      chk("t5_req_valid", BLOCKSZ'(req_valid), '0);
      chk("t5_max_latency", BLOCKSZ'(max_latency), '0);
      lat_cfg = 2;
      wait_served(s0 + 2);
      steps(2);
      chk("t5_order_a", BLOCKSZ'(served[s0]), BLOCKSZ'(1));
      chk("t5_order_b", BLOCKSZ'(served[s0+1]), BLOCKSZ'(3));
      chk("t5_pulses", BLOCKSZ'(vcount - v0), BLOCKSZ'(2));
      chk("t5_max_after", BLOCKSZ'(max_latency), BLOCKSZ'(2));

      // 6: spurious reader valid outside a fetch
      s0 = served.size(); v0 = vcount; saved = req_data;
      spur = 1'b1;
      steps(6);
      chk("t6_no_serve", BLOCKSZ'(served.size()), BLOCKSZ'(s0));
      chk("t6_data_hold", req_data, saved);
      chk("t6_no_pulse", BLOCKSZ'(vcount - v0), '0);
      want[0] = 1;
      wait_served(s0 + 1);
      steps(4);
      chk("t6_data", req_data, last_block);
      chk("t6_one_pulse", BLOCKSZ'(vcount - v0), BLOCKSZ'(1));
      spur = 1'b0;
      steps(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
